// File: rtl/pll_seq_pkg.sv
// Shared state encodings and counter sizing for the rPLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

  localparam int RELOCK_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync2_ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rPLL reset sequencer: holds the PLL in reset, waits for a stable lock with
// bounded retries, then releases the downstream reset; re-sequences on lock loss.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pll_lock_i,
  input  logic                restart_i,
  output logic                pll_reset_o,
  output logic                sys_reset_no,
  output logic                locked_o,
  output logic                fault_o,
  output logic [2:0]          state_o,
  output logic [RELOCK_W-1:0] relock_count_o
);

  localparam int TW = $clog2(max3(HOLD_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRIES);

  logic lock_s;

  sync2_ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock_i),
    .q       (lock_s)
  );

  seq_state_e          state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RW-1:0]       retries_q, retries_d, retries_inc;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_reset_q, pll_reset_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retries_d   = retries_q;
    relock_d    = relock_q;
    retries_inc = retries_q + 1'b1;

    if (restart_i) begin
      state_d   = ST_HOLD;
      timer_d   = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (timer_q >= HOLD_LAST) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT: begin
          // The lock cycle seen here is the first of the stable run.
          if (lock_s) begin
            state_d = ST_STABLE;
            timer_d = TW'(1);
          end else if (timer_q >= TO_LAST) begin
            timer_d   = '0;
            retries_d = retries_inc;
            state_d   = (retries_inc >= RETRY_LIM) ? ST_FAULT : ST_HOLD;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end else if (timer_q >= STABLE_LAST) begin
            state_d   = ST_RUN;
            timer_d   = '0;
            retries_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_HOLD;
            timer_d = '0;
            if (relock_q != '1) relock_d = relock_q + 1'b1;
          end
        end
        ST_FAULT: ;
        default: begin
          state_d = ST_HOLD;
          timer_d = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    locked_d    = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      timer_q     <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset_o    = pll_reset_q;
  assign sys_reset_no   = sys_rst_n_q;
  assign locked_o       = locked_q;
  assign fault_o        = fault_q;
  assign state_o        = state_q;
  assign relock_count_o = relock_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scenario bench for pll_reset_seq; expected timelines are computed from the
// sequencing rules as edge counts relative to reset release / input changes.
module tb_pll_reset_seq;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;

  logic       clock = 1'b0;
  logic       reset_n, pll_lock_i, restart_i;
  logic       pll_reset_o, sys_reset_no, locked_o, fault_o;
  logic [2:0] state_o;
  logic [7:0] relock_count_o;

  int tests = 0;
  int fails = 0;

  pll_reset_seq #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT),
    .STABLE_CYCLES(STABLE), .MAX_RETRIES(RETRIES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pll_lock_i(pll_lock_i), .restart_i(restart_i),
    .pll_reset_o(pll_reset_o), .sys_reset_no(sys_reset_no), .locked_o(locked_o),
    .fault_o(fault_o), .state_o(state_o), .relock_count_o(relock_count_o)
  );

  always #5 clock = ~clock;

  // Observed/expected vector layout: {pll_reset, sys_reset_n, locked, fault, state}
  function automatic logic [6:0] pk(input bit pr, input bit sr, input bit lk,
                                    input bit ft, input int st);
    return {pr, sr, lk, ft, 3'(st)};
  endfunction

  wire [6:0] obs = {pll_reset_o, sys_reset_no, locked_o, fault_o, state_o};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pll_lock_i = 1'b0; restart_i = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input int st, input int budget, input string nm);
    int n = 0;
    while (state_o !== 3'(st) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (state_o !== 3'(st)) begin
      fails++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", nm, state_o, st, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_lock_i = 1'b1; restart_i = 1'b0;
    repeat (3) tick();
    tests++;
    if (obs !== pk(1, 0, 0, 0, 0) || relock_count_o !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: got %b/%0d, required %b/0", obs, relock_count_o, pk(1, 0, 0, 0, 0));
    end
  endtask

  // lock rises after edge L; lock_s is seen by the FSM at edge L+3
  task automatic test_lock_up(input int L);
    int d, r;
    logic [6:0] exp;
    do_reset();
    d = (L + 3 > HOLD + 1) ? L + 3 : HOLD + 1;
    r = d + STABLE - 1;
    for (int e = 1; e <= r + 2; e++) begin
      tick();
      exp = pk(e < HOLD, e >= r, e >= r, 0,
               (e < HOLD) ? 0 : (e < d) ? 1 : (e < r) ? 2 : 3);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL lock_up L=%0d edge %0d: got %b, required %b", L, e, obs, exp);
      end
      if (e == L) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_timeout();
    int att = HOLD + TIMEOUT;
    int f   = RETRIES * att;
    int k;
    logic [6:0] exp;
    do_reset();
    for (int e = 1; e <= f + 5; e++) begin
      tick();
      k = e % att;
      if (e >= f) exp = pk(1, 0, 0, 1, 4);
      else if (k < HOLD) exp = pk(1, 0, 0, 0, 0);
      else exp = pk(0, 0, 0, 0, 1);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL timeout edge %0d: got %b, required %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_restart_fault();
    do_reset();
    wait_state(4, 100, "reach_fault");
    repeat ($urandom_range(1, 5)) tick();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    tests++;
    if (obs !== pk(1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL restart_fault: got %b, required %b", obs, pk(1, 0, 0, 0, 0));
    end
    // With retries cleared, the first timeout goes back to HOLD, the second to FAULT.
    for (int k = 1; k <= 2 * (HOLD + TIMEOUT); k++) begin
      tick();
      if (k == HOLD || k == HOLD + TIMEOUT || k == 2 * (HOLD + TIMEOUT)) begin
        int st = (k == HOLD) ? 1 : (k == HOLD + TIMEOUT) ? 0 : 4;
        tests++;
        if (state_o !== 3'(st)) begin
          fails++;
          $display("FAIL retries_cleared k=%0d: state %0d, required %0d", k, state_o, st);
        end
      end
    end
  endtask

  task automatic lose_lock(input int n);
    pll_lock_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (k < 3 && sys_reset_no !== 1'b1) begin
        fails++;
        $display("FAIL relock_early k=%0d: sys_reset_no %b, required 1", k, sys_reset_no);
      end else if (k == 3 && (obs !== pk(1, 0, 0, 0, 0) || relock_count_o !== 8'(n))) begin
        fails++;
        $display("FAIL relock n=%0d: got %b/%0d, required %b/%0d",
                 n, obs, relock_count_o, pk(1, 0, 0, 0, 0), n);
      end
    end
  endtask

  task automatic test_relock();
    do_reset();
    pll_lock_i = 1'b1;
    wait_state(3, 60, "reach_run");
    for (int n = 1; n <= 3; n++) begin
      repeat ($urandom_range(1, 10)) tick();
      lose_lock(n);
      repeat ($urandom_range(0, 6)) tick();
      pll_lock_i = 1'b1;
      wait_state(3, 60, "rerun");
    end
  endtask

  task automatic test_saturate();
    for (int n = 4; n <= 257; n++) begin
      pll_lock_i = 1'b0;
      repeat (3) tick();
      pll_lock_i = 1'b1;
      wait_state(3, 60, "sat_rerun");
    end
    tests++;
    if (relock_count_o !== 8'd255) begin
      fails++;
      $display("FAIL relock_saturate: got %0d, required 255", relock_count_o);
    end
  endtask

  // glitch: lock low after edge g, high again after edge g+1
  task automatic test_glitch(input int g);
    logic [6:0] exp;
    int st;
    do_reset();
    for (int e = 1; e <= g + 13; e++) begin
      tick();
      st = (e < HOLD) ? 0 : (e == HOLD) ? 1 : (e <= g + 2) ? 2 :
           (e == g + 3) ? 1 : (e < g + 3 + STABLE) ? 2 : 3;
      exp = pk(e < HOLD, st == 3, st == 3, 0, st);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL glitch g=%0d edge %0d: got %b, required %b", g, e, obs, exp);
      end
      if (e == 2) pll_lock_i = 1'b1;
      if (e == g) pll_lock_i = 1'b0;
      if (e == g + 1) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_restart_run();
    do_reset();
    pll_lock_i = 1'b1;
    wait_state(3, 60, "rr_run");
    repeat ($urandom_range(1, 8)) tick();
    pll_lock_i = 1'b0;
    repeat (2) tick();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    tests++;
    if (obs !== pk(1, 0, 0, 0, 0) || relock_count_o !== 8'd0) begin
      fails++;
      $display("FAIL restart_vs_loss: got %b/%0d, required %b/0", obs, relock_count_o, pk(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    do_reset();
    pll_lock_i = 1'b1;
    wait_state(3, 60, "ar_run");
    pll_lock_i = 1'b0;
    repeat (4) tick();
    pll_lock_i = 1'b1;
    wait_state(2, 40, "ar_stable");
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== pk(1, 0, 0, 0, 0) || relock_count_o !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got %b/%0d, required %b/0", obs, relock_count_o, pk(1, 0, 0, 0, 0));
    end
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= HOLD + 1; e++) begin
      tick();
      exp = pk(e < HOLD, 0, 0, 0, (e < HOLD) ? 0 : (e == HOLD) ? 1 : 2);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL hold_after_reset edge %0d: got %b, required %b", e, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up(10);
    repeat (4) test_lock_up($urandom_range(1, 20));
    test_timeout();
    test_restart_fault();
    test_relock();
    test_saturate();
    test_glitch(3);
    repeat (3) test_glitch($urandom_range(3, 9));
    test_restart_run();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
